// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// access sizes, mcause codes and the access legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        FAULT
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    // Unsigned sizes only exist for loads, so a store with f3[2] set is illegal.
    function automatic logic access_legal(input logic [2:0] f3,
                                          input logic [1:0] addr_lo,
                                          input logic       is_store);
        logic legal;
        case (f3)
            F3_B, F3_BU: legal = 1'b1;
            F3_H, F3_HU: legal = ~addr_lo[0];
            F3_W:        legal = (addr_lo == 2'b00);
            default:     legal = 1'b0;
        endcase
        if (is_store && f3[2])
            legal = 1'b0;
        return legal;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: store byte enables and data replication,
// plus load lane extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_val
);

    logic [31:0] lane;

    always_comb begin
        lane      = rdata >> {offset, 3'b000};
        be        = 4'b1111;
        wdata_rep = wdata;
        load_val  = lane;

        case (f3[1:0])
            2'b00: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase

        case (f3)
            F3_B:    load_val = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   load_val = {24'h0, lane[7:0]};
            F3_H:    load_val = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   load_val = {16'h0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage with a request/ack data bus and fault reporting.
// Define LSU_TIMEOUT_EN to fault a bus access that is not acked in time.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        except,
    output logic [3:0]  except_cause,
    output logic [31:0] except_info,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    generate
        if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_check
            $error("CNT_W is too narrow to count to TIMEOUT_CYCLES");
        end
    endgenerate

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        req;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] load_val;
`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
`endif

    assign req   = mem_rd | mem_wr;
    assign legal = access_legal(f3, addr[1:0], mem_wr);

    lsu_lane_align u_lane_align (
        .f3        (f3_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (bus_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .load_val  (load_val)
    );

    // Stall must rise in the accept cycle itself, so it is decoded, not registered.
    assign stall     = rst_n & (((state == IDLE) & req) | (state == BUSY));
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be    = bus_req ? be : 4'b0000;
    assign bus_wdata = (bus_req & we_q) ? wdata_rep : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            f3_q         <= '0;
            we_q         <= 1'b0;
            bus_req      <= 1'b0;
            done         <= 1'b0;
            except       <= 1'b0;
            except_cause <= '0;
            except_info  <= '0;
            read_data    <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            done         <= 1'b0;
            except       <= 1'b0;
            except_cause <= '0;
            except_info  <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= addr;
                        we_q   <= mem_wr;
                        if (legal) begin
                            f3_q    <= f3;
                            wdata_q <= wdata;
                            bus_req <= 1'b1;
                            state   <= BUSY;
`ifdef LSU_TIMEOUT_EN
                            cnt     <= '0;
`endif
                        end else begin
                            except       <= 1'b1;
                            except_cause <= mem_wr ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                            except_info  <= addr;
                            state        <= FAULT;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the last allowed cycle takes precedence over the timeout.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        if (!we_q)
                            read_data <= load_val;
                        state   <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus_req      <= 1'b0;
                        except       <= 1'b1;
                        except_cause <= we_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                        except_info  <= addr_q;
                        state        <= FAULT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit; timeout sequence is
// compiled in only when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        except;
    logic [3:0]  except_cause;
    logic [31:0] except_info;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cycle;
        logic        fault;
        logic [3:0]  cause;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        we;
        logic [31:0] rdval;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .f3           (f3),
        .addr         (addr),
        .wdata        (wdata),
        .read_data    (read_data),
        .stall        (stall),
        .done         (done),
        .except       (except),
        .except_cause (except_cause),
        .except_info  (except_info),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one access from the table and follows it through to IDLE.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(posedge clk); #1;
        mem_rd = v.rd; mem_wr = v.wr; f3 = v.f3; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        checkOutput($sformatf("v%0d accept stall", idx), {31'b0, stall}, 32'd1);
        checkOutput($sformatf("v%0d accept bus_req", idx), {31'b0, bus_req}, 32'd0);
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
        if (v.fault) begin
            @(negedge clk);
            checkOutput($sformatf("v%0d except", idx), {31'b0, except}, 32'd1);
            checkOutput($sformatf("v%0d except_cause", idx), {28'b0, except_cause}, {28'b0, v.cause});
            checkOutput($sformatf("v%0d except_info", idx), except_info, v.addr);
            checkOutput($sformatf("v%0d fault bus_req", idx), {31'b0, bus_req}, 32'd0);
            checkOutput($sformatf("v%0d fault stall", idx), {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput($sformatf("v%0d except cleared", idx), {31'b0, except}, 32'd0);
        end else begin
            for (int k = 1; k <= v.ack_cycle; k++) begin
                bus_ack = (k == v.ack_cycle);
                bus_rdata = v.rdata;
                @(negedge clk);
                checkOutput($sformatf("v%0d busy%0d bus_req", idx, k), {31'b0, bus_req}, 32'd1);
                checkOutput($sformatf("v%0d busy%0d stall", idx, k), {31'b0, stall}, 32'd1);
                if (k == 1) begin
                    checkOutput($sformatf("v%0d bus_addr", idx), bus_addr, v.baddr);
                    checkOutput($sformatf("v%0d bus_be", idx), {28'b0, bus_be}, {28'b0, v.be});
                    checkOutput($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwdata);
                    checkOutput($sformatf("v%0d bus_we", idx), {31'b0, bus_we}, {31'b0, v.we});
                end
                if (k < v.ack_cycle) begin
                    @(posedge clk); #1;
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = 32'h0;
            @(negedge clk);
            checkOutput($sformatf("v%0d done", idx), {31'b0, done}, 32'd1);
            checkOutput($sformatf("v%0d done stall", idx), {31'b0, stall}, 32'd0);
            checkOutput($sformatf("v%0d done bus_req", idx), {31'b0, bus_req}, 32'd0);
            if (!v.we)
                checkOutput($sformatf("v%0d read_data", idx), read_data, v.rdval);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput($sformatf("v%0d done cleared", idx), {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        //          rd    wr    f3     addr          wdata         rdata         ack fault cause be       baddr         bwdata        we    rdval
        vecs[0]  = '{1'b1, 1'b0, F3_W,  32'h00000100, 32'h0,        32'hDEADBEEF, 2, 1'b0, 4'd0, 4'b1111, 32'h00000100, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, F3_B,  32'h00000103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'd0, 4'b1000, 32'h00000100, 32'h0,        1'b0, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, F3_BU, 32'h00000103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'd0, 4'b1000, 32'h00000100, 32'h0,        1'b0, 32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, F3_H,  32'h00000102, 32'h1234ABCD, 32'h0,        1, 1'b0, 4'd0, 4'b1100, 32'h00000100, 32'hABCDABCD, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, F3_W,  32'h00000102, 32'h0,        32'h0,        1, 1'b1, 4'd4, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, F3_W,  32'h00000101, 32'h0,        32'h0,        1, 1'b1, 4'd6, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, F3_H,  32'h00000102, 32'h0,        32'h80FF0000, 1, 1'b0, 4'd0, 4'b1100, 32'h00000100, 32'h0,        1'b0, 32'hFFFF80FF};
        vecs[7]  = '{1'b1, 1'b0, F3_HU, 32'h00000100, 32'h0,        32'h1234F00D, 1, 1'b0, 4'd0, 4'b0011, 32'h00000100, 32'h0,        1'b0, 32'h0000F00D};
        vecs[8]  = '{1'b0, 1'b1, F3_B,  32'h00000101, 32'h000000A5, 32'h0,        1, 1'b0, 4'd0, 4'b0010, 32'h00000100, 32'hA5A5A5A5, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, F3_W,  32'h00000200, 32'hCAFEF00D, 32'h0,        3, 1'b0, 4'd0, 4'b1111, 32'h00000200, 32'hCAFEF00D, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h00000100, 32'h0,       32'h0,        1, 1'b1, 4'd4, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, F3_BU, 32'h00000100, 32'h0,        32'h0,        1, 1'b1, 4'd6, 4'b0000, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[12] = '{1'b1, 1'b1, F3_W,  32'h00000104, 32'h11223344, 32'h0,        1, 1'b0, 4'd0, 4'b1111, 32'h00000104, 32'h11223344, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 1'b0, F3_H,  32'h00000101, 32'h0,        32'h0,        1, 1'b1, 4'd4, 4'b0000, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, F3_B,  32'h00000101, 32'h0,        32'h00007F00, 1, 1'b0, 4'd0, 4'b0010, 32'h00000100, 32'h0,        1'b0, 32'h0000007F};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset read_data", read_data, 32'h0);
        checkOutput("reset flags", {27'b0, stall, done, except, bus_req, bus_we}, 32'h0);
        checkOutput("reset bus_be", {28'b0, bus_be}, 32'h0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++)
            applyStimulus(vecs[i], i);

        // Asynchronous reset in the middle of a bus access.
        @(posedge clk); #1;
        mem_rd = 1'b1; f3 = F3_W; addr = 32'h00000100;
        @(posedge clk); #1;
        mem_rd = 1'b0;
        @(negedge clk);
        checkOutput("pre-reset bus_req", {31'b0, bus_req}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset bus_req", {31'b0, bus_req}, 32'd0);
        checkOutput("async reset stall", {31'b0, stall}, 32'd0);
        checkOutput("async reset done", {31'b0, done}, 32'd0);
        checkOutput("async reset bus_addr", bus_addr, 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        applyStimulus(vecs[0], 100);

`ifdef LSU_TIMEOUT_EN
        // Load that is never acked faults after four BUSY cycles.
        @(posedge clk); #1;
        mem_rd = 1'b1; f3 = F3_W; addr = 32'h00000100;
        @(posedge clk); #1;
        mem_rd = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("timeout busy%0d bus_req", k), {31'b0, bus_req}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("timeout bus_req dropped", {31'b0, bus_req}, 32'd0);
        checkOutput("timeout except", {31'b0, except}, 32'd1);
        checkOutput("timeout cause", {28'b0, except_cause}, 32'd5);
        checkOutput("timeout info", except_info, 32'h00000100);
        applyStimulus('{1'b1, 1'b0, F3_W, 32'h00000100, 32'h0, 32'h55AA1234, 4, 1'b0, 4'd0,
                        4'b1111, 32'h00000100, 32'h0, 1'b0, 32'h55AA1234}, 200);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
